// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The optional statistics counters are enabled by FIFO_WR_ARB_STAT_EN.
package fifo_wr_arb_pkg;

    localparam int DW_DEF = 32;
    localparam int LW_DEF = 2;
    localparam int STAT_W = 8;

    // 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BURST0 = 2'b01,
        BURST1 = 2'b10
    } state_t;

endpackage

// File: rtl/fifo_wr_arb_ns.sv
// Combinational next-state, burst-counter and round-robin logic for fifo_wr_arb.
// state | meaning: IDLE = no owner, BURST0 = producer 0 owns port, BURST1 = producer 1 owns port
module fifo_wr_arb_ns
    import fifo_wr_arb_pkg::*;
#(
    parameter int LW = LW_DEF
) (
    input  state_t          state_i,
    input  logic [LW-1:0]   beat_cnt_i,
    input  logic            last_i,
    input  logic            req0_i,
    input  logic [LW-1:0]   len0_i,
    input  logic            req1_i,
    input  logic [LW-1:0]   len1_i,
    input  logic            fifo_full_i,
    output state_t          state_o,
    output logic [LW-1:0]   beat_cnt_o,
    output logic            last_o,
    output logic            abort_o
);

    logic do_arb;
    logic arb_last;

    always_comb begin
        state_o    = IDLE;
        beat_cnt_o = beat_cnt_i;
        last_o     = last_i;
        abort_o    = 1'b0;
        do_arb     = 1'b0;
        arb_last   = last_i;

        case (state_i)
            IDLE: do_arb = 1'b1;
            BURST0: begin
                if (!req0_i) begin
                    last_o  = 1'b0;
                    abort_o = 1'b1;
                end else if (fifo_full_i) begin
                    state_o = BURST0;
                end else if (beat_cnt_i != '0) begin
                    state_o    = BURST0;
                    beat_cnt_o = beat_cnt_i - LW'(1);
                end else begin
                    last_o   = 1'b0;
                    arb_last = 1'b0;
                    do_arb   = 1'b1;
                end
            end
            BURST1: begin
                if (!req1_i) begin
                    last_o  = 1'b1;
                    abort_o = 1'b1;
                end else if (fifo_full_i) begin
                    state_o = BURST1;
                end else if (beat_cnt_i != '0) begin
                    state_o    = BURST1;
                    beat_cnt_o = beat_cnt_i - LW'(1);
                end else begin
                    last_o   = 1'b1;
                    arb_last = 1'b1;
                    do_arb   = 1'b1;
                end
            end
            default: state_o = IDLE;
        endcase

        // On a tie the producer not served last wins
        if (do_arb) begin
            if (req0_i && (!req1_i || arb_last)) begin
                state_o    = BURST0;
                beat_cnt_o = len0_i;
            end else if (req1_i) begin
                state_o    = BURST1;
                beat_cnt_o = len1_i;
            end else begin
                state_o = IDLE;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Two-producer round-robin write-port arbiter with burst lock for the 8-entry FIFO.
// Define FIFO_WR_ARB_STAT_EN to add saturating beat and stall counters.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic [LW-1:0]   len0,
    input  logic [DW-1:0]   din0,
    input  logic            req1,
    input  logic [LW-1:0]   len1,
    input  logic [DW-1:0]   din1,
    input  logic            fifo_full,
    output logic            gnt0,
    output logic            gnt1,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_din,
    output logic            abort
`ifdef FIFO_WR_ARB_STAT_EN
    ,
    output logic [STAT_W-1:0] beats0,
    output logic [STAT_W-1:0] beats1,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    state_t          state_q, state_d;
    logic [LW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            last_q, last_d;
    logic            abort_q, abort_d;

    fifo_wr_arb_ns #(.LW(LW)) u_ns (
        .state_i     (state_q),
        .beat_cnt_i  (beat_cnt_q),
        .last_i      (last_q),
        .req0_i      (req0),
        .len0_i      (len0),
        .req1_i      (req1),
        .len1_i      (len1),
        .fifo_full_i (fifo_full),
        .state_o     (state_d),
        .beat_cnt_o  (beat_cnt_d),
        .last_o      (last_d),
        .abort_o     (abort_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            last_q     <= 1'b1;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
        end
    end

    // Grants are masked while reset is held so the write port is quiet from time zero
    assign gnt0       = (state_q == BURST0) && !reset;
    assign gnt1       = (state_q == BURST1) && !reset;
    assign fifo_wr_en = ((gnt0 && req0) || (gnt1 && req1)) && !fifo_full;
    assign fifo_din   = gnt1 ? din1 : (gnt0 ? din0 : '0);
    assign abort      = abort_q;

`ifdef FIFO_WR_ARB_STAT_EN
    logic [STAT_W-1:0] beats0_q, beats1_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beats0_q <= '0;
            beats1_q <= '0;
            stall_q  <= '0;
        end else begin
            if (fifo_wr_en && gnt0 && (beats0_q != '1))
                beats0_q <= beats0_q + STAT_W'(1);
            if (fifo_wr_en && gnt1 && (beats1_q != '1))
                beats1_q <= beats1_q + STAT_W'(1);
            if ((gnt0 || gnt1) && fifo_full && (stall_q != '1))
                stall_q <= stall_q + STAT_W'(1);
        end
    end

    assign beats0    = beats0_q;
    assign beats1    = beats1_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, table-driven bench for fifo_wr_arb; each record is one clock cycle.
module tb_fifo_wr_arb;

    logic        clk;
    logic        reset;
    logic        req0, req1, fifo_full;
    logic [1:0]  len0, len1;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1, fifo_wr_en, abort;
    logic [31:0] fifo_din;
`ifdef FIFO_WR_ARB_STAT_EN
    logic [7:0]  beats0, beats1, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arb #(.DW(32), .LW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .len0       (len0),
        .din0       (din0),
        .req1       (req1),
        .len1       (len1),
        .din1       (din1),
        .fifo_full  (fifo_full),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .abort      (abort)
`ifdef FIFO_WR_ARB_STAT_EN
        ,
        .beats0     (beats0),
        .beats1     (beats1),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        q0;
        logic [1:0]  l0;
        logic [31:0] d0;
        logic        q1;
        logic [1:0]  l1;
        logic [31:0] d1;
        logic        full;
        logic        g0;
        logic        g1;
        logic        we;
        logic [31:0] dout;
        logic        ab;
    } vec_t;

    function automatic vec_t V(input string nm, input logic rst,
                               input logic q0, input logic [1:0] l0, input logic [31:0] d0,
                               input logic q1, input logic [1:0] l1, input logic [31:0] d1,
                               input logic full, input logic g0, input logic g1,
                               input logic we, input logic [31:0] dout, input logic ab);
        vec_t v;
        v.name = nm; v.rst = rst;
        v.q0 = q0; v.l0 = l0; v.d0 = d0;
        v.q1 = q1; v.l1 = l1; v.d1 = d1;
        v.full = full;
        v.g0 = g0; v.g1 = g1; v.we = we; v.dout = dout; v.ab = ab;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check before the rising edge
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst;
        req0 = v.q0; len0 = v.l0; din0 = v.d0;
        req1 = v.q1; len1 = v.l1; din1 = v.d1;
        fifo_full = v.full;
        #1;
        chk({v.name, ".gnt0"},       {31'd0, gnt0},       {31'd0, v.g0});
        chk({v.name, ".gnt1"},       {31'd0, gnt1},       {31'd0, v.g1});
        chk({v.name, ".fifo_wr_en"}, {31'd0, fifo_wr_en}, {31'd0, v.we});
        chk({v.name, ".fifo_din"},   fifo_din,            v.dout);
        chk({v.name, ".abort"},      {31'd0, abort},      {31'd0, v.ab});
    endtask

    vec_t tbl[$];
    vec_t rst_v;
    int   nb;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; len0 = '0; din0 = '0;
        req1 = 1'b0; len1 = '0; din1 = '0;
        fifo_full = 1'b0;

        rst_v = V("rst", 1, 0,0,32'h0, 0,0,32'h0, 0, 0,0,0,32'h0,0);

        // Single burst of 3, re-granted on its final beat, then dropped
        tbl.push_back(rst_v);
        tbl.push_back(rst_v);
        tbl.push_back(V("A_req",   0, 1,2,32'hA0, 0,0,0, 0, 0,0,0,32'h0 ,0));
        tbl.push_back(V("A_b0",    0, 1,2,32'hA0, 0,0,0, 0, 1,0,1,32'hA0,0));
        tbl.push_back(V("A_b1",    0, 1,2,32'hA1, 0,0,0, 0, 1,0,1,32'hA1,0));
        tbl.push_back(V("A_b2",    0, 1,2,32'hA2, 0,0,0, 0, 1,0,1,32'hA2,0));
        tbl.push_back(V("A_drop",  0, 0,2,32'hA3, 0,0,0, 0, 1,0,0,32'hA3,0));
        tbl.push_back(V("A_idle",  0, 0,2,32'hA3, 0,0,0, 0, 0,0,0,32'h0 ,1));
        tbl.push_back(V("A_quiet", 0, 0,2,32'hA3, 0,0,0, 0, 0,0,0,32'h0 ,0));
        // Tie with single-beat bursts: strict alternation, producer 0 first
        tbl.push_back(rst_v);
        tbl.push_back(V("B_req",   0, 1,0,32'h10, 1,0,32'h20, 0, 0,0,0,32'h0 ,0));
        tbl.push_back(V("B_g0a",   0, 1,0,32'h10, 1,0,32'h20, 0, 1,0,1,32'h10,0));
        tbl.push_back(V("B_g1a",   0, 1,0,32'h10, 1,0,32'h20, 0, 0,1,1,32'h20,0));
        tbl.push_back(V("B_g0b",   0, 1,0,32'h10, 1,0,32'h20, 0, 1,0,1,32'h10,0));
        tbl.push_back(V("B_g1b",   0, 1,0,32'h10, 1,0,32'h20, 0, 0,1,1,32'h20,0));
        // Back-to-back: req1 rises mid-burst, handover without idle cycle
        tbl.push_back(rst_v);
        tbl.push_back(V("E_req",   0, 1,1,32'h60, 0,0,32'h0 , 0, 0,0,0,32'h0 ,0));
        tbl.push_back(V("E_b0",    0, 1,1,32'h60, 1,0,32'h70, 0, 1,0,1,32'h60,0));
        tbl.push_back(V("E_b1",    0, 1,1,32'h61, 1,0,32'h70, 0, 1,0,1,32'h61,0));
        tbl.push_back(V("E_g1",    0, 1,1,32'h61, 1,0,32'h70, 0, 0,1,1,32'h70,0));
        tbl.push_back(V("E_g0",    0, 1,1,32'h61, 1,0,32'h70, 0, 1,0,1,32'h61,0));

        foreach (tbl[i]) apply(tbl[i]);

        // Full stall in a 4-beat producer-1 burst after its second beat
        apply(rst_v);
        nb = 0;
        apply(V("C_req",  0, 0,0,32'h0, 1,3,32'h30, 0, 0,0,0,32'h0 ,0)); nb += int'(fifo_wr_en);
        apply(V("C_b0",   0, 0,0,32'h0, 1,3,32'h30, 0, 0,1,1,32'h30,0)); nb += int'(fifo_wr_en);
        apply(V("C_b1",   0, 0,0,32'h0, 1,3,32'h31, 0, 0,1,1,32'h31,0)); nb += int'(fifo_wr_en);
        apply(V("C_st0",  0, 0,0,32'h0, 1,3,32'h32, 1, 0,1,0,32'h32,0)); nb += int'(fifo_wr_en);
        apply(V("C_st1",  0, 0,0,32'h0, 1,3,32'h32, 1, 0,1,0,32'h32,0)); nb += int'(fifo_wr_en);
        chk("C_cnt_hold1", {30'd0, dut.beat_cnt_q}, 32'd1);
        apply(V("C_st2",  0, 0,0,32'h0, 1,3,32'h32, 1, 0,1,0,32'h32,0)); nb += int'(fifo_wr_en);
        chk("C_cnt_hold2", {30'd0, dut.beat_cnt_q}, 32'd1);
        apply(V("C_b2",   0, 0,0,32'h0, 1,3,32'h32, 0, 0,1,1,32'h32,0)); nb += int'(fifo_wr_en);
        chk("C_cnt_hold3", {30'd0, dut.beat_cnt_q}, 32'd1);
`ifdef FIFO_WR_ARB_STAT_EN
        chk("C_stall_cnt", {24'd0, stall_cnt}, 32'd3);
`endif
        apply(V("C_b3",   0, 0,0,32'h0, 1,3,32'h33, 0, 0,1,1,32'h33,0)); nb += int'(fifo_wr_en);
        chk("C_beats", nb, 32'd4);

        // Producer 0 drops after one beat of a 4-beat burst while producer 1 waits
        apply(rst_v);
        apply(V("D_req",  0, 1,3,32'h40, 1,1,32'h50, 0, 0,0,0,32'h0 ,0));
        apply(V("D_b0",   0, 1,3,32'h40, 1,1,32'h50, 0, 1,0,1,32'h40,0));
        apply(V("D_drop", 0, 0,3,32'h41, 1,1,32'h50, 0, 1,0,0,32'h41,0));
        apply(V("D_abrt", 0, 0,3,32'h41, 1,1,32'h50, 0, 0,0,0,32'h0 ,1));
        apply(V("D_g1",   0, 0,3,32'h41, 1,1,32'h50, 0, 0,1,1,32'h50,0));

        // Reset during a producer-1 burst: no abort, next tie goes to producer 0
        apply(rst_v);
        apply(V("F_req",  0, 0,0,32'h0 , 1,3,32'h80, 0, 0,0,0,32'h0 ,0));
        apply(V("F_b0",   0, 0,0,32'h0 , 1,3,32'h80, 0, 0,1,1,32'h80,0));
        apply(V("F_rst",  1, 0,0,32'h0 , 1,3,32'h81, 0, 0,0,0,32'h0 ,0));
        apply(V("F_tie",  0, 1,0,32'h90, 1,0,32'h81, 0, 0,0,0,32'h0 ,0));
        apply(V("F_g0",   0, 1,0,32'h90, 1,0,32'h81, 0, 1,0,1,32'h90,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Two-requester, round-robin write-port arbiter with burst lock for the 8-entry FIFO.
- Grants the FIFO write port to one producer for a whole burst of 1-4 beats.
- Drives the FIFO's write enable and write data, and stalls while the FIFO reports full.
- Sits between two producer blocks and the FIFO write interface. The read side is untouched.

Parameters:
- DW, 32: data width of each producer input and of fifo_din.
- LW, 2: width of the burst-length fields. A burst is len+1 beats, so 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  producer 0 request. Held high for the whole burst.
- len0  input  LW  producer 0 burst length minus 1. Sampled only when the burst is granted.
- din0  input  DW  producer 0 write data for the current beat.
- req1  input  1  producer 1 request.
- len1  input  LW  producer 1 burst length minus 1.
- din1  input  DW  producer 1 write data.
- fifo_full  input  1  FIFO full flag. While high, no beat is accepted.
- gnt0  output  1  producer 0 owns the write port (registered).
- gnt1  output  1  producer 1 owns the write port (registered).
- fifo_wr_en  output  1  write strobe to the FIFO (combinational).
- fifo_din  output  DW  write data to the FIFO (combinational mux).
- abort  output  1  one-cycle pulse: the burst owner dropped its request mid-burst.

Behaviour:
- States (2-bit): IDLE=00, BURST0=01, BURST1=10. Encoding 11 is illegal and goes to IDLE on the next edge.
- Registered state:
  - state;
  - beat_cnt[LW-1:0]: beats remaining minus 1;
  - last: last producer served;
  - abort.
- Reset values: state=IDLE, beat_cnt=0, last=1 (so producer 0 wins the first tie), abort=0.
- Output values during reset: gnt0=0, gnt1=0, fifo_wr_en=0, fifo_din=0.
- gnt0 = (state==BURST0) and gnt1 = (state==BURST1), both decoded from registered state.
- fifo_wr_en = (gnt0&req0 | gnt1&req1) & ~fifo_full.
- fifo_din = din1 when gnt1, else din0 when gnt0, else 0.
- Beat accepted ⇔ fifo_wr_en=1 at a rising edge. The producer advances its data after every accepted beat.
- Grant latency: a request first seen in IDLE produces its grant on the next cycle. The first write can occur in that grant cycle.
- Arbitration, used in IDLE and on a burst's final beat:
  - both requesting: grant the producer ≠ last;
  - one requesting: grant that producer;
  - none requesting: go to IDLE.
  - On every grant, beat_cnt ← len of the winner.
- BURSTx, accepted beat, beat_cnt≠0: beat_cnt decrements and state holds.
- BURSTx, accepted beat, beat_cnt==0 (final beat):
  - last ← x;
  - re-arbitrate in the same edge (back-to-back bursts, no idle bubble). The other producer wins if it is requesting.
- BURSTx with fifo_full=1: state and beat_cnt hold. No write, no timeout.
- BURSTx with reqx=0 (dropped mid-burst):
  - next state is IDLE, last ← x, abort pulses for 1 cycle;
  - the partial burst stays in the FIFO (no rollback).
- Drop and full in the same cycle: the drop takes precedence.
- The other producer may assert or deassert its request freely during a burst. It is not sampled until the burst ends.
- Reset mid-burst: state goes to IDLE immediately and the burst is lost. No abort pulse.

Optional Feature:
- Macro: FIFO_WR_ARB_STAT_EN.
- When defined, adds outputs:
  - beats0 and beats1 (8-bit): accepted-beat counters per producer, saturating at 255;
  - stall_cnt (8-bit): cycles in BURSTx with fifo_full=1, saturating at 255.
- All three counters clear on reset.
- When not defined: these ports and registers do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package fifo_wr_arb_pkg holds:
  - state localparams IDLE, BURST0, BURST1 and a 2-bit state typedef;
  - default DW and LW;
  - the stat counter width (8).
- Sub-module fifo_wr_arb_ns: purely combinational next-state and beat_cnt-load logic.
  - Inputs: state, beat_cnt, last, req0/1, len0/1, fifo_full.
  - The top level holds the registers, the data mux and the optional counters.

Test Plan:
- Single burst, no contention:
  - Stimulus: reset; req0=1, len0=2, din0 increments 0xA0, 0xA1, 0xA2.
  - Required: gnt0 high on the next cycle; 3 writes 0xA0..0xA2 on consecutive cycles; then IDLE with gnt0=0.
- Tie and round-robin:
  - Stimulus: req0=req1=1, len0=len1=0, held.
  - Required: grants alternate 0,1,0,1 each cycle with a write every cycle; the first grant goes to producer 0 after reset.
- Full stall:
  - Stimulus: BURST1 with len1=3; fifo_full=1 for 3 cycles after the second beat.
  - Required: fifo_wr_en=0 during the stall; beat_cnt holds at 1; 4 beats total; stall_cnt=3 when FIFO_WR_ARB_STAT_EN is defined.
- Mid-burst drop:
  - Stimulus: req0 drops after beat 1 of a 4-beat burst while req1=1.
  - Required: abort pulses for 1 cycle; IDLE; then gnt1 on the following cycle.
- Back-to-back with the other producer waiting:
  - Stimulus: producer 0 in a 2-beat burst; req1 rises mid-burst.
  - Required: on the final beat the state goes directly to BURST1 with no IDLE cycle.
- Reset mid-burst:
  - Stimulus: assert reset during BURST1.
  - Required: gnt1=0 and fifo_wr_en=0 on the next cycle; abort=0; the next tie grants producer 0.
